// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - Shared PS/2 frame constants, states and command codes.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INHIBIT  = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_BITS     = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_WAITIDLE = 3'd5;

  localparam int DATA_BITS  = 8;
  localparam int PARITY_IDX = 8;
  localparam int STOP_IDX   = 9;

  typedef enum logic [7:0] {
    CMD_SET_LEDS = 8'hED,
    CMD_ENABLE   = 8'hF4,
    CMD_RESET    = 8'hFF
  } ps2_cmd_e;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - PS/2 line synchroniser, clock debounce and falling-edge pulse.
module ps2_filter #(
  parameter int FILT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic ck_i,
  input  logic d_i,
  output logic ck_sync,
  output logic d_sync,
  output logic fall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    ck_sync_q, ck_sync_d;
  logic [1:0]    d_sync_q, d_sync_d;
  logic          ck_filt_q, ck_filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_d;

  always_comb begin
    ck_sync_d = ck_sync_q;
    d_sync_d  = d_sync_q;
    ck_filt_d = ck_filt_q;
    cnt_d     = cnt_q;
    fall_d    = 1'b0;
    if (ce) begin
      ck_sync_d = {ck_sync_q[0], ck_i};
      d_sync_d  = {d_sync_q[0], d_i};
      // The new level is accepted on the FILT-th consecutive differing sample.
      if (ck_sync_q[1] == ck_filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(FILT - 1)) begin
        ck_filt_d = ck_sync_q[1];
        cnt_d     = '0;
        fall_d    = ck_filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync_q <= 2'b11;
      d_sync_q  <= 2'b11;
      ck_filt_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      ck_sync_q <= ck_sync_d;
      d_sync_q  <= d_sync_d;
      ck_filt_q <= ck_filt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ck_sync = ck_sync_q[1];
  assign d_sync  = d_sync_q[1];
  assign fall    = fall_d;

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - Host-to-device PS/2 command transmitter with ACK check and timeout.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT = 840,
  parameter int TIMEOUT = 105000,
  parameter int FILT    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2CkI,
  input  logic       ps2DI,
  output logic       ps2CkO,
  output logic       ps2DO,
  input  logic       strb,
  input  logic [7:0] d,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          ck_sync, d_sync, fall;
  logic [2:0]    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [3:0]    n_q, n_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ck_o_q, ck_o_d;
  logic          d_o_q, d_o_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  ps2_filter #(.FILT(FILT)) u_filter (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ck_i    (ps2CkI),
    .d_i     (ps2DI),
    .ck_sync (ck_sync),
    .d_sync  (d_sync),
    .fall    (fall)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    n_d     = n_q;
    icnt_d  = icnt_q;
    tmo_d   = tmo_q;
    ck_o_d  = ck_o_q;
    d_o_d   = d_o_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (strb) begin
            data_d  = d;
            par_d   = odd_parity(d);
            err_d   = 1'b0;
            busy_d  = 1'b1;
            ck_o_d  = 1'b0;
            icnt_d  = '0;
            state_d = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (icnt_q == IW'(INHIBIT - 1)) begin
            ck_o_d  = 1'b1;
            d_o_d   = 1'b0;
            tmo_d   = '0;
            state_d = ST_REQ;
          end else begin
            icnt_d = icnt_q + 1'b1;
          end
        end
        default: begin
          // Timeout wins over any fall seen on the same tick.
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            ck_o_d  = 1'b1;
            d_o_d   = 1'b1;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
            case (state_q)
              ST_REQ: begin
                if (fall) begin
                  d_o_d   = data_q[0];
                  n_d     = 4'd1;
                  state_d = ST_BITS;
                end
              end
              ST_BITS: begin
                if (fall) begin
                  n_d = n_q + 1'b1;
                  if (n_q < 4'(PARITY_IDX)) begin
                    d_o_d = data_q[n_q[2:0]];
                  end else if (n_q == 4'(PARITY_IDX)) begin
                    d_o_d = par_q;
                  end else begin
                    d_o_d   = 1'b1;
                    state_d = ST_ACK;
                  end
                end
              end
              ST_ACK: begin
                if (fall) begin
                  if (d_sync) err_d = 1'b1;
                  state_d = ST_WAITIDLE;
                end
              end
              ST_WAITIDLE: begin
                if (ck_sync && d_sync) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
                end
              end
              default: begin
                ck_o_d  = 1'b1;
                d_o_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      n_q     <= '0;
      icnt_q  <= '0;
      tmo_q   <= '0;
      ck_o_q  <= 1'b1;
      d_o_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      n_q     <= n_d;
      icnt_q  <= icnt_d;
      tmo_q   <= tmo_d;
      ck_o_q  <= ck_o_d;
      d_o_q   <= d_o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ps2CkO = ck_o_q;
  assign ps2DO  = d_o_q;
  assign busy   = busy_q;
  // done_q is held until the next ce tick; gating with ce makes it one ce-aligned clock.
  assign done   = done_q & ce;
  assign err    = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - Self-checking bench for ps2_tx with a behavioural keyboard model.
module tb_ps2_tx;

  localparam int INH = 40;
  localparam int TMO = 2000;
  localparam int FLT = 4;
  localparam int H   = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       strb = 1'b0;
  logic [7:0] d = 8'h00;
  logic       dev_ck = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2CkI, ps2DI, ps2CkO, ps2DO, busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  assign ps2CkI = ps2CkO & dev_ck;
  assign ps2DI  = ps2DO & dev_d;

  ps2_tx #(.INHIBIT(INH), .TIMEOUT(TMO), .FILT(FLT)) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .ps2CkI (ps2CkI),
    .ps2DI  (ps2DI),
    .ps2CkO (ps2CkO),
    .ps2DO  (ps2DO),
    .strb   (strb),
    .d      (d),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      #2;
      ce = ~ce;
    end
  end

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cetick();
    @(posedge clock);
    while (!ce) @(posedge clock);
    #1;
  endtask

  task automatic send_strb(input logic [7:0] b);
    d = b;
    strb = 1'b1;
    cetick();
    strb = 1'b0;
    check("ck_low_after_strb", ps2CkO, 0);
    check("busy_after_strb", busy, 1);
    check("err_cleared", err, 0);
  endtask

  task automatic check_inhibit();
    int n;
    n = 0;
    while (ps2CkO === 1'b0 && n < INH + 10) begin
      cetick();
      n++;
    end
    check("inhibit_ticks", n, INH);
    check("start_bit", ps2DO, 0);
  endtask

  task automatic dev_frame(input int nclk, input bit ack, input bit glitch,
                           output logic [9:0] bits, output int unstable);
    logic v;
    unstable = 0;
    bits = '0;
    repeat (H) cetick();
    for (int k = 1; k <= nclk; k++) begin
      dev_ck = 1'b0;
      if (glitch && k == 5) begin
        d = 8'hFF;
        strb = 1'b1;
        cetick();
        strb = 1'b0;
      end
      repeat (H) cetick();
      v = ps2DO;
      if (k <= 10) bits[k-1] = v;
      dev_ck = 1'b1;
      for (int j = 0; j < H; j++) begin
        cetick();
        if (ps2DO !== v) unstable++;
      end
      if (k == 10 && ack) dev_d = 1'b0;
      if (k == 11) dev_d = 1'b1;
    end
  endtask

  task automatic wait_done(input int base, input logic exp_err);
    int t;
    t = 0;
    while (busy === 1'b1 && t < TMO + 100) begin
      cetick();
      t++;
    end
    check("busy_released", busy, 0);
    cetick();
    check("done_once", done_cnt - base, 1);
    check("err_status", err, exp_err);
    check("ck_released", ps2CkO, 1);
    check("d_released", ps2DO, 1);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input bit glitch);
    int base, unst;
    logic [9:0] bits;
    logic par;
    base = done_cnt;
    send_strb(b);
    check_inhibit();
    dev_frame(11, ack, glitch, bits, unst);
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    check("frame_bits", bits, {1'b1, par, b});
    check("data_stable_ck_high", unst, 0);
    wait_done(base, ~ack);
  endtask

  initial begin
    int base, t, unst;
    logic [9:0] bits;
    logic [7:0] b;

    repeat (3) @(posedge clock);
    #1;
    check("rst_ck", ps2CkO, 1);
    check("rst_d", ps2DO, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    repeat (10) cetick();

    xfer(8'hED, 1'b1, 1'b1);
    xfer(8'h00, 1'b1, 1'b0);
    xfer(8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      xfer(b, 1'b1, 1'b0);
    end
    b = 8'($urandom);
    xfer(b, 1'b0, 1'b0);

    base = done_cnt;
    send_strb(8'($urandom));
    check_inhibit();
    t = 0;
    while (busy === 1'b1 && t < TMO + 50) begin
      cetick();
      t++;
    end
    check("timeout_ticks", t, TMO);
    cetick();
    check("timeout_done", done_cnt - base, 1);
    check("timeout_err", err, 1);
    check("timeout_ck", ps2CkO, 1);
    check("timeout_d", ps2DO, 1);

    base = done_cnt;
    send_strb(8'h00);
    check_inhibit();
    dev_frame(4, 1'b0, 1'b0, bits, unst);
    dev_ck = 1'b0;
    repeat (3) cetick();
    check("pre_reset_d_low", ps2DO, 0);
    reset = 1'b0;
    #1;
    check("mid_reset_ck", ps2CkO, 1);
    check("mid_reset_d", ps2DO, 1);
    check("mid_reset_busy", busy, 0);
    dev_ck = 1'b1;
    repeat (5) cetick();
    reset = 1'b1;
    repeat (20) cetick();
    check("mid_reset_no_done", done_cnt - base, 0);
    xfer(8'hF4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter. It is the transmit counterpart of the existing ps2 receiver and shares the keyboard port with it. It sends one command byte, for example 0xED set-LEDs or 0xFF reset, to the keyboard: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop bit, then checks for the device ACK. Outputs are open-drain enables that are wired-AND with the pad; the receiver ignores frames while busy=1.

Parameters:
INHIBIT, 840, ce ticks the clock line is held low before the request (120 us at 7 MHz).
TIMEOUT, 105000, ce ticks allowed from clock release until the transfer completes (15 ms at 7 MHz).
FILT, 4, consecutive identical ce samples required to accept a new level on the filtered ps2 clock.

Ports:
clock  in  1  system clock; the single clock.
reset  in  1  asynchronous, active-low reset.
ce  in  1  clock enable (pe7M0); all state advances only when ce=1.
ps2CkI  in  1  pad level of the PS/2 clock line.
ps2DI  in  1  pad level of the PS/2 data line.
ps2CkO  out  1  0 = drive clock line low, 1 = release.
ps2DO  out  1  0 = drive data line low, 1 = release.
strb  in  1  transmit request, sampled on a ce cycle.
d  in  8  byte to send, captured when strb is accepted.
busy  out  1  transfer in progress.
done  out  1  one-clock pulse on a ce cycle at the end of a transfer.
err  out  1  status of the last transfer (1 = timeout or missing ACK); valid from done until the next accepted strb.

Behaviour:
- Reset (reset=0, async): ps2CkO=1, ps2DO=1, busy=0, done=0, err=0, state=IDLE, all counters cleared. A reset mid-transfer releases both lines immediately.
- Input conditioning:
  - ps2CkI and ps2DI each pass through a 2-flop synchroniser.
  - The clock is then filtered: the filtered level changes only after FILT consecutive ce samples of the new level.
  - fall = filtered clock 1→0, detected on a ce cycle.
- IDLE: lines released. On ce and strb, latch d and compute parity = ~^d (odd), clear err, busy=1, then go to INHIBIT. strb while busy=1 is ignored.
- INHIBIT: ps2CkO=0 for INHIBIT ce ticks. On the last tick, set ps2DO=0 (start bit) and go to REQ.
- REQ: ps2CkO=1 (release), ps2DO held 0. The timeout counter starts at 0 and runs through REQ, BITS, ACK and WAITIDLE.
- BITS: bit counter n=0..9 advances on each fall.
  - On fall n: drive ps2DO = d[n] for n=0..7, parity for n=8, and 1 (release, stop) for n=9.
  - After n=9, go to ACK.
- ACK: on the next fall, sample filtered/synced data.
  - Data 0 → ACK good; go to WAITIDLE.
  - Data 1 → err=1; go to WAITIDLE.
- WAITIDLE: wait until synced clock=1 and data=1, then pulse done, set busy=0, and go to IDLE.
- Timeout: when the counter reaches TIMEOUT in any of REQ..WAITIDLE:
  - release both lines, set err=1, pulse done, busy=0, go to IDLE;
  - a fall in the same cycle is discarded.
- Level rule: ps2DO changes only during the low phase that follows a fall; it never changes while the device clock is high.
- done is exactly one clock wide and coincides with a ce cycle. err is a level.
- Latency:
  - strb → ps2CkO low: 1 ce cycle.
  - Data low after clock low: INHIBIT ticks.
  - Device-paced thereafter.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, REQ, BITS, ACK, WAITIDLE), frame constants (DATA_BITS=8, PARITY_IDX=8, STOP_IDX=9), common command codes (0xED, 0xF4, 0xFF) for callers.
- Sub-module ps2_filter: 2-flop synchroniser + FILT-sample debounce + falling-edge pulse. Reusable by the receiver.

Test Plan:
- strb with d=0xED; device model clocks at 12.5 kHz and ACKs. Required:
  - clock held low 840 ce ticks, then data low;
  - sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done pulses once; err=0; busy low after the lines go idle.
- d=0x00 → parity bit 1. d=0x01 → parity bit 0. Both end with err=0.
- Device never clocks → exactly 105000 ce ticks after clock release: done pulse, err=1, ps2CkO=ps2DO=1.
- Device clocks but holds data high at the 11th fall → err=1, done pulse, no hang.
- strb re-asserted with d=0xFF during the 0xED transfer → ignored; the frame still carries 0xED; only one done.
- reset=0 asserted mid-BITS → both lines release immediately; busy=0. The next strb with d=0xF4 completes normally.
